// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy count, programmable almost flags and optional FWFT read.
// Optional sticky overflow/underflow error flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_flags #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 2**DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int             CAP   = 2**DEPTH;
  localparam logic [DEPTH:0] CAP_C = (DEPTH+1)'(CAP);
  localparam logic [DEPTH:0] AF_C  = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_C  = (DEPTH+1)'(AE_LEVEL);
  localparam logic [DEPTH:0] ONE_C = (DEPTH+1)'(32'd1);
  localparam logic [DEPTH:0] NIL_C = (DEPTH+1)'(32'd0);

  if (!((AE_LEVEL >= 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= CAP))) begin : g_level_check
    $fatal(1, "sync_fifo_flags: levels must satisfy 0 <= AE_LEVEL < AF_LEVEL <= 2**DEPTH");
  end

  logic [WIDTH-1:0] mem_r [CAP];
  logic [DEPTH:0]   wr_ptr_r;
  logic [DEPTH:0]   rd_ptr_r;
  logic [DEPTH:0]   count_r;
  logic [DEPTH:0]   count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             almost_full_r;
  logic             almost_empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A pop frees a slot at the same edge, so a full FIFO still accepts a push alongside it.
  assign pop_ok_s  = read_en && !empty_r;
  assign push_ok_s = write_en && (!full_r || pop_ok_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and flags; flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= NIL_C;
      rd_ptr_r       <= NIL_C;
      count_r        <= NIL_C;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + ONE_C;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ONE_C;
      count_r        <= count_next_s;
      full_r         <= (count_next_s == CAP_C);
      empty_r        <= (count_next_s == NIL_C);
      almost_full_r  <= (count_next_s >= AF_C);
      almost_empty_r <= (count_next_s <= AE_C);
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[DEPTH-1:0]] <= data_in;
  end

  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; gated to zero while empty so reset leaves data_out at zero.
    assign data_out   = empty_r ? '0 : mem_r[rd_ptr_r[DEPTH-1:0]];
    assign data_valid = !empty_r;
  end else begin : g_std
    logic [WIDTH-1:0] data_out_r;
    logic             data_valid_r;

    // Registered read port: word appears one cycle after the accepting pop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_out_r   <= '0;
        data_valid_r <= 1'b0;
      end else begin
        data_valid_r <= pop_ok_s;
        if (pop_ok_s) data_out_r <= mem_r[rd_ptr_r[DEPTH-1:0]];
      end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;
  logic ovf_set_s;
  logic unf_set_s;

  assign ovf_set_s = write_en && full_r && !pop_ok_s;
  assign unf_set_s = read_en && empty_r;

  // Sticky error flags; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s || (overflow_r && !err_clr);
      underflow_r <= unf_set_s || (underflow_r && !err_clr);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  logic err_clr_unused_s;

  assign err_clr_unused_s = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised scoreboard bench for sync_fifo_flags: a standard-read and an FWFT instance share
// one stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 3;
  localparam int WIDTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CAP   = 8;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             write_en = 1'b0;
  logic             read_en = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] data_in = 8'h00;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_valid, f_valid, s_full, f_full, s_empty, f_empty;
  logic             s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [DEPTH:0]   s_count, f_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_out = 8'h00;
  bit               exp_valid = 1'b0;
  bit               exp_ovf = 1'b0;
  bit               exp_unf = 1'b0;
  bit               mon_en = 1'b0;

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(s_dout), .data_valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
  );

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(f_dout), .data_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string p, input logic [DEPTH:0] cnt, input logic fl, input logic em,
                           input logic af, input logic ae, input logic ov, input logic un);
    int n;
    n = model_q.size();
    chk({p, "_count"}, 32'(cnt), 32'(n));
    chk({p, "_full"}, 32'(fl), 32'(n == CAP));
    chk({p, "_empty"}, 32'(em), 32'(n == 0));
    chk({p, "_almost_full"}, 32'(af), 32'(n >= AF));
    chk({p, "_almost_empty"}, 32'(ae), 32'(n <= AE));
    chk({p, "_overflow"}, 32'(ov), 32'(exp_ovf));
    chk({p, "_underflow"}, 32'(un), 32'(exp_unf));
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_q.delete();
    last_out  = 8'h00;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // One clock of stimulus: the model decides acceptance from its own occupancy, then advances at the edge.
  task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input bit clr);
    bit pop_ok, push_ok, ovf_set, unf_set;
    logic [WIDTH-1:0] w;
    write_en = wr;
    read_en  = rd;
    data_in  = d;
    err_clr  = clr;
    pop_ok   = rd && (model_q.size() != 0);
    push_ok  = wr && ((model_q.size() != CAP) || pop_ok);
    ovf_set  = ERR_EN && wr && (model_q.size() == CAP) && !pop_ok;
    unf_set  = ERR_EN && rd && (model_q.size() == 0);
    @(posedge clk);
    if (pop_ok) begin
      w = model_q.pop_front();
      exp_q.push_back(w);
      last_out = w;
    end
    if (push_ok) model_q.push_back(d);
    exp_valid = pop_ok;
    exp_ovf   = ovf_set || (exp_ovf && !clr);
    exp_unf   = unf_set || (exp_unf && !clr);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_std_count", 32'(s_count), 32'd0);
    chk("rst_std_empty", 32'(s_empty), 32'd1);
    chk("rst_std_full", 32'(s_full), 32'd0);
    chk("rst_std_ae", 32'(s_ae), 32'd1);
    chk("rst_std_af", 32'(s_af), 32'd0);
    chk("rst_std_dout", 32'(s_dout), 32'd0);
    chk("rst_std_valid", 32'(s_valid), 32'd0);
    chk("rst_std_ovf", 32'(s_ovf), 32'd0);
    chk("rst_std_unf", 32'(s_unf), 32'd0);
    chk("rst_fwft_count", 32'(f_count), 32'd0);
    chk("rst_fwft_empty", 32'(f_empty), 32'd1);
    chk("rst_fwft_valid", 32'(f_valid), 32'd0);
    chk("rst_fwft_dout", 32'(f_dout), 32'd0);
  endtask

  task automatic do_reset();
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    reset    = 1'b1;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
  endtask

  // Monitor: compares every cycle against the model and drains the scoreboard on each data_valid.
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    if (!reset && mon_en) begin
      chk_flags("std", s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf);
      chk_flags("fwft", f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf);
      chk("std_valid", 32'(s_valid), 32'(exp_valid));
      if (s_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL std_unexpected_valid: got data %0h with empty scoreboard at %0t", s_dout, $time);
        end else begin
          w = exp_q.pop_front();
          chk("std_data", 32'(s_dout), 32'(w));
        end
      end else begin
        if (exp_valid && exp_q.size() != 0) w = exp_q.pop_front();
        chk("std_hold", 32'(s_dout), 32'(last_out));
      end
      chk("fwft_valid", 32'(f_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) chk("fwft_head", 32'(f_dout), 32'(model_q[0]));
    end
  end

  initial begin
    bit wr, rd, clr;
    int pw, pr;
    do_reset();
    mon_en = 1'b1;

    // Three pushes then three pops through the standard read port.
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    chk("fill3_count", 32'(s_count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain3_empty", 32'(s_empty), 32'd1);

    // Fill to capacity, then a rejected push, then clear the error.
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, 8'(8'h40 + 8'(i)), 1'b0);
    chk("full_flag", 32'(s_full), 32'd1);
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Push and pop together while full; 0xAA must come out last.
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("full_pushpop_count", 32'(s_count), 32'd8);
    for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("last_word_aa", 32'(s_dout), 32'hAA);

    // Push and pop together while empty, then a lone pop on empty.
    step(1'b1, 1'b1, 8'h05, 1'b0);
    chk("empty_pushpop_count", 32'(s_count), 32'd1);
    chk("empty_pushpop_novalid", 32'(s_valid), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // FWFT head visible right after the writing edge.
    step(1'b1, 1'b0, 8'h77, 1'b0);
    chk("fwft_77_dout", 32'(f_dout), 32'h77);
    chk("fwft_77_empty", 32'(f_empty), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Randomised phases: fill-heavy, drain-heavy, balanced.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      wr  = ($urandom_range(99) < pw);
      rd  = ($urandom_range(99) < pr);
      clr = ($urandom_range(39) == 0);
      step(wr, rd, 8'($urandom), clr);
    end

    // Asynchronous reset in the middle of a fill.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h90 + 8'(i)), 1'b0);
    chk("midfill_count", 32'(f_count), 32'd5);
    write_en = 1'b0;
    #2 reset = 1'b1;
    clear_model();
    #1;
    chk("async_fwft_count", 32'(f_count), 32'd0);
    chk("async_fwft_empty", 32'(f_empty), 32'd1);
    chk("async_std_count", 32'(s_count), 32'd0);
    chk("async_std_empty", 32'(s_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
